// File: rtl/loader_pkg.sv
// loader_pkg: region map types, default address map and FSM encoding
// shared by the ROM region loader and its address decoder
package loader_pkg;

  localparam int MAX_REGIONS = 9;

  typedef struct packed {
    logic [31:0] base;
    logic [31:0] size;
  } region_t;

  typedef region_t [0:MAX_REGIONS-1] region_map_t;

  localparam region_map_t LOADER_MAP = '{
    '{base: 32'h0000_0000, size: 32'h0010_0000},
    '{base: 32'h0010_0000, size: 32'h0000_4000},
    '{base: 32'h0010_4000, size: 32'h0000_4000},
    '{base: 32'h0010_8000, size: 32'h0000_2000},
    '{base: 32'h0010_A000, size: 32'h0000_2000},
    '{base: 32'h0010_C000, size: 32'h0000_1000},
    '{base: 32'h0010_D000, size: 32'h0000_1000},
    '{base: 32'h0000_0000, size: 32'h0000_0000},
    '{base: 32'h0000_0000, size: 32'h0000_0000}
  };

  typedef enum logic [1:0] {
    S_IDLE,
    S_PAIR,
    S_WRITE,
    S_FLUSH
  } state_t;

endpackage

// File: rtl/loader_region_decode.sv
// loader_region_decode: combinational byte address to region lookup
// entry 0 is SDRAM, entry k+1 is BRAM k; first matching entry wins
module loader_region_decode
  import loader_pkg::*;
#(
  parameter int          NUM_BRAM = 6,
  parameter int          ADDR_W   = 25,
  parameter int          BRAM_AW  = 20,
  parameter region_map_t REGIONS  = LOADER_MAP
) (
  input  logic [ADDR_W-1:0]   addr_i,
  output logic                hit_o,
  output logic                sdr_o,
  output logic [NUM_BRAM-1:0] sel_o,
  output logic [BRAM_AW-1:0]  off_o
);

  logic [32:0] a;
  logic [32:0] lo;
  logic [32:0] hi;

  // scan high to low so the lowest matching entry has the last word
  always_comb begin
    a     = 33'(addr_i);
    lo    = '0;
    hi    = '0;
    hit_o = 1'b0;
    sdr_o = 1'b0;
    sel_o = '0;
    off_o = '0;
    for (int i = NUM_BRAM; i >= 0; i--) begin
      lo = {1'b0, REGIONS[i].base};
      hi = lo + {1'b0, REGIONS[i].size};
      if (a >= lo && a < hi) begin
        hit_o = 1'b1;
        sdr_o = (i == 0);
        sel_o = NUM_BRAM'((1 << i) >> 1);
        off_o = BRAM_AW'(a - lo);
      end
    end
  end

endmodule

// File: rtl/rom_region_loader.sv
// rom_region_loader: steers ioctl download bytes into SDRAM words
// or BRAM regions, pairing SDRAM bytes into 16-bit writes
module rom_region_loader
  import loader_pkg::*;
#(
  parameter int          NUM_BRAM = 6,
  parameter int          ADDR_W   = 25,
  parameter int          BRAM_AW  = 20,
  parameter region_map_t REGIONS  = LOADER_MAP
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ioctl_download,
  input  logic                ioctl_wr,
  input  logic [ADDR_W-1:0]   ioctl_addr,
  input  logic [7:0]          ioctl_data,
  output logic                ioctl_wait,
  output logic [ADDR_W-1:0]   sdr_addr,
  output logic [15:0]         sdr_data,
  output logic [1:0]          sdr_be,
  output logic                sdr_req,
  input  logic                sdr_rdy,
  output logic [BRAM_AW-1:0]  bram_addr,
  output logic [7:0]          bram_data,
  output logic [NUM_BRAM-1:0] bram_cs,
  output logic                bram_wr,
  output logic                done,
  output logic                err,
  output logic [ADDR_W-1:0]   byte_count
);

  state_t              state_q, state_d;
  logic                skid_v_q, skid_v_d;
  logic [ADDR_W-1:0]   skid_addr_q, skid_addr_d;
  logic [7:0]          skid_data_q, skid_data_d;
  logic [ADDR_W-1:0]   sdr_addr_q, sdr_addr_d;
  logic [15:0]         sdr_data_q, sdr_data_d;
  logic [1:0]          sdr_be_q, sdr_be_d;
  logic                bram_wr_q, bram_wr_d;
  logic [NUM_BRAM-1:0] bram_cs_q, bram_cs_d;
  logic [BRAM_AW-1:0]  bram_addr_q, bram_addr_d;
  logic [7:0]          bram_data_q, bram_data_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                armed_q, armed_d;
  logic                dl_q;

  logic                in_v;
  logic                busy;
  logic                free;
  logic                pair;
  logic                acc;
  logic                dl_rise;
  logic                same_w;
  logic [ADDR_W-1:0]   src_addr;
  logic [7:0]          src_data;
  logic                dec_hit;
  logic                dec_sdr;
  logic [NUM_BRAM-1:0] dec_sel;
  logic [BRAM_AW-1:0]  dec_off;

  assign in_v    = ioctl_download & ioctl_wr;
  assign busy    = (state_q == S_WRITE) | (state_q == S_FLUSH);
  assign free    = ~busy | sdr_rdy;
  assign pair    = (state_q == S_PAIR);
  assign dl_rise = ioctl_download & ~dl_q;
  assign same_w  = src_addr[ADDR_W-1:1] == sdr_addr_q[ADDR_W-1:1];

  // a parked byte goes ahead of anything new so order is kept
  always_comb begin
    src_addr = skid_v_q ? skid_addr_q : ioctl_addr;
    src_data = skid_v_q ? skid_data_q : ioctl_data;
  end

  loader_region_decode #(
    .NUM_BRAM (NUM_BRAM),
    .ADDR_W   (ADDR_W),
    .BRAM_AW  (BRAM_AW),
    .REGIONS  (REGIONS)
  ) u_dec (
    .addr_i (src_addr),
    .hit_o  (dec_hit),
    .sdr_o  (dec_sdr),
    .sel_o  (dec_sel),
    .off_o  (dec_off)
  );

  // state and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      skid_v_q    <= 1'b0;
      skid_addr_q <= '0;
      skid_data_q <= '0;
      sdr_addr_q  <= '0;
      sdr_data_q  <= '0;
      sdr_be_q    <= '0;
      bram_wr_q   <= 1'b0;
      bram_cs_q   <= '0;
      bram_addr_q <= '0;
      bram_data_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      armed_q     <= 1'b0;
      dl_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      skid_v_q    <= skid_v_d;
      skid_addr_q <= skid_addr_d;
      skid_data_q <= skid_data_d;
      sdr_addr_q  <= sdr_addr_d;
      sdr_data_q  <= sdr_data_d;
      sdr_be_q    <= sdr_be_d;
      bram_wr_q   <= bram_wr_d;
      bram_cs_q   <= bram_cs_d;
      bram_addr_q <= bram_addr_d;
      bram_data_q <= bram_data_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      armed_q     <= armed_d;
      dl_q        <= ioctl_download;
    end
  end

  // next state: a completing write frees the engine on the same edge
  always_comb begin
    state_d     = state_q;
    skid_v_d    = skid_v_q;
    skid_addr_d = skid_addr_q;
    skid_data_d = skid_data_q;
    sdr_addr_d  = sdr_addr_q;
    sdr_data_d  = sdr_data_q;
    sdr_be_d    = sdr_be_q;
    bram_wr_d   = 1'b0;
    bram_cs_d   = '0;
    bram_addr_d = bram_addr_q;
    bram_data_d = bram_data_q;
    err_d       = dl_rise ? 1'b0 : err_q;
    cnt_d       = dl_rise ? '0 : cnt_q;
    acc         = 1'b0;
    if (busy & sdr_rdy) state_d = S_IDLE;
    if (!free) begin
      if (in_v & skid_v_q) begin
        err_d = 1'b1;
      end else if (in_v) begin
        skid_v_d    = 1'b1;
        skid_addr_d = ioctl_addr;
        skid_data_d = ioctl_data;
      end
    end else begin
      if (in_v & skid_v_q) err_d = 1'b1;
      skid_v_d = 1'b0;
      if (skid_v_q | in_v) begin
        if (!dec_hit) begin
          err_d = 1'b1;
        end else if (pair & (~dec_sdr | ~src_addr[0] | ~same_w)) begin
          state_d     = S_FLUSH;
          sdr_be_d    = 2'b01;
          skid_v_d    = 1'b1;
          skid_addr_d = src_addr;
          skid_data_d = src_data;
        end else if (!dec_sdr) begin
          bram_wr_d   = 1'b1;
          bram_cs_d   = dec_sel;
          bram_addr_d = dec_off;
          bram_data_d = src_data;
          acc         = 1'b1;
        end else if (pair) begin
          state_d          = S_WRITE;
          sdr_data_d[15:8] = src_data;
          sdr_be_d         = 2'b11;
          acc              = 1'b1;
        end else if (src_addr[0]) begin
          state_d    = S_WRITE;
          sdr_addr_d = {src_addr[ADDR_W-1:1], 1'b0};
          sdr_data_d = {src_data, 8'h00};
          sdr_be_d   = 2'b10;
          acc        = 1'b1;
        end else begin
          state_d    = S_PAIR;
          sdr_addr_d = src_addr;
          sdr_data_d = {8'h00, src_data};
          sdr_be_d   = 2'b00;
          acc        = 1'b1;
        end
      end else if (pair & ~ioctl_download) begin
        state_d  = S_FLUSH;
        sdr_be_d = 2'b01;
      end
    end
    if (acc) cnt_d = cnt_d + ADDR_W'(1);
    done_d  = armed_q & ~ioctl_download &
              (state_q == S_IDLE) & ~skid_v_q;
    armed_d = ioctl_download | (armed_q & ~done_d);
  end

  // outputs decoded from state
  always_comb begin
    ioctl_wait = busy | skid_v_q;
    sdr_req    = busy;
  end

  assign sdr_addr   = sdr_addr_q;
  assign sdr_data   = sdr_data_q;
  assign sdr_be     = sdr_be_q;
  assign bram_wr    = bram_wr_q;
  assign bram_cs    = bram_cs_q;
  assign bram_addr  = bram_addr_q;
  assign bram_data  = bram_data_q;
  assign done       = done_q;
  assign err        = err_q;
  assign byte_count = cnt_q;

endmodule

// File: tb/tb_rom_region_loader.sv
// tb_rom_region_loader: directed and randomized checks of the loader
// against memory images built from the bytes the bench sent
module tb_rom_region_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_data;
  logic        ioctl_wait;
  logic [24:0] sdr_addr;
  logic [15:0] sdr_data;
  logic [1:0]  sdr_be;
  logic        sdr_req;
  logic        sdr_rdy;
  logic [19:0] bram_addr;
  logic [7:0]  bram_data;
  logic [5:0]  bram_cs;
  logic        bram_wr;
  logic        done;
  logic        err;
  logic [24:0] byte_count;

  always #5 clk = ~clk;

  rom_region_loader dut (
    .clk            (clk),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_data     (ioctl_data),
    .ioctl_wait     (ioctl_wait),
    .sdr_addr       (sdr_addr),
    .sdr_data       (sdr_data),
    .sdr_be         (sdr_be),
    .sdr_req        (sdr_req),
    .sdr_rdy        (sdr_rdy),
    .bram_addr      (bram_addr),
    .bram_data      (bram_data),
    .bram_cs        (bram_cs),
    .bram_wr        (bram_wr),
    .done           (done),
    .err            (err),
    .byte_count     (byte_count)
  );

  typedef struct {
    logic [24:0] a;
    logic [15:0] d;
    logic [1:0]  be;
  } sw_t;

  typedef struct {
    logic [5:0]  cs;
    logic [19:0] a;
    logic [7:0]  d;
  } bw_t;

  sw_t sq[$];
  bw_t bq[$];

  int n_chk = 0;
  int n_fail = 0;
  int lat = 2;
  int age = 0;
  int done_cnt = 0;
  int wait_bad = 0;
  int hold_bad = 0;
  int req_cyc = 0;
  logic [24:0] h_a;
  logic [15:0] h_d;
  logic [1:0]  h_be;

  int bbase[6] = '{32'h100000, 32'h104000, 32'h108000,
                   32'h10A000, 32'h10C000, 32'h10D000};
  int bsize[6] = '{32'h4000, 32'h4000, 32'h2000,
                   32'h2000, 32'h1000, 32'h1000};

  // SDRAM channel model and write monitors
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (bram_wr) bq.push_back('{bram_cs, bram_addr, bram_data});
    if (reset) begin
      sdr_rdy = 1'b0;
      age = 0;
    end else if (sdr_rdy) begin
      sdr_rdy = 1'b0;
      age = 0;
    end else if (sdr_req) begin
      req_cyc++;
      if (!ioctl_wait) wait_bad++;
      if (age > 0 && (sdr_addr !== h_a || sdr_data !== h_d ||
                      sdr_be !== h_be)) hold_bad++;
      h_a  = sdr_addr;
      h_d  = sdr_data;
      h_be = sdr_be;
      age++;
      if (age >= lat) begin
        sq.push_back('{sdr_addr, sdr_data, sdr_be});
        sdr_rdy = 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic sw_t sqw(input int i);
    sw_t w;
    w.a = '1;
    w.d = '1;
    w.be = '1;
    if (i < sq.size()) w = sq[i];
    return w;
  endfunction

  function automatic bw_t bqw(input int i);
    bw_t w;
    w.cs = '1;
    w.a = '1;
    w.d = '1;
    if (i < bq.size()) w = bq[i];
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [24:0] a, input logic [7:0] d);
    int n = 0;
    while (ioctl_wait && n < 200) begin
      tick();
      n++;
    end
    chk("wait_bound", 64'(n < 200), 64'd1);
    ioctl_wr = 1'b1;
    ioctl_addr = a;
    ioctl_data = d;
    tick();
    ioctl_wr = 1'b0;
  endtask

  task automatic start_dl();
    ioctl_download = 1'b1;
    tick();
  endtask

  task automatic end_dl();
    int n = 0;
    int d0 = done_cnt;
    ioctl_download = 1'b0;
    while (done_cnt == d0 && n < 300) begin
      tick();
      n++;
    end
    repeat (4) tick();
    chk("done_once", 64'(done_cnt - d0), 64'd1);
  endtask

  function automatic int region_of(input logic [24:0] a);
    if (a < 25'h100000) return 0;
    for (int k = 0; k < 6; k++)
      if (int'(a) >= bbase[k] && int'(a) < bbase[k] + bsize[k])
        return k + 1;
    return -1;
  endfunction

  logic [7:0] exp_s[int];
  logic [7:0] exp_b[int];
  logic [7:0] got_s[int];
  logic [7:0] got_b[int];

  initial begin
    sw_t w;
    bw_t b;
    logic [24:0] a;
    logic [24:0] prev;
    logic [7:0]  d;
    int r;
    int reg_k;
    int exp_cnt;
    int exp_err;
    int bad_a0;
    int bad_cs;
    int k_found;
    int c0;

    reset = 1'b1;
    ioctl_download = 1'b0;
    ioctl_wr = 1'b0;
    ioctl_addr = '0;
    ioctl_data = '0;
    sdr_rdy = 1'b0;
    repeat (3) tick();
    chk("rst_req", 64'(sdr_req), 64'd0);
    chk("rst_wait", 64'(ioctl_wait), 64'd0);
    chk("rst_be", 64'(sdr_be), 64'd0);
    chk("rst_bram_wr", 64'(bram_wr), 64'd0);
    chk("rst_cs", 64'(bram_cs), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_cnt", 64'(byte_count), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    reset = 1'b0;
    tick();

    // four sequential SDRAM bytes pair into two full words
    lat = 2;
    sq.delete();
    start_dl();
    for (int i = 0; i < 4; i++) send(25'(i), 8'(i));
    end_dl();
    chk("pair_n", 64'(sq.size()), 64'd2);
    w = sqw(0);
    chk("pair0_a", 64'(w.a), 64'h0);
    chk("pair0_d", 64'(w.d), 64'h0100);
    chk("pair0_be", 64'(w.be), 64'h3);
    w = sqw(1);
    chk("pair1_a", 64'(w.a), 64'h2);
    chk("pair1_d", 64'(w.d), 64'h0302);
    chk("pair1_be", 64'(w.be), 64'h3);
    chk("pair_cnt", 64'(byte_count), 64'd4);
    chk("pair_wait", 64'(wait_bad), 64'd0);

    // lone odd byte writes the high lane only
    sq.delete();
    start_dl();
    chk("cnt_clear", 64'(byte_count), 64'd0);
    send(25'd5, 8'hAA);
    end_dl();
    chk("odd_n", 64'(sq.size()), 64'd1);
    w = sqw(0);
    chk("odd_a", 64'(w.a), 64'h4);
    chk("odd_hi", 64'(w.d[15:8]), 64'hAA);
    chk("odd_be", 64'(w.be), 64'h2);

    // held low byte flushed by a BRAM byte, then the BRAM write
    sq.delete();
    bq.delete();
    start_dl();
    send(25'd8, 8'h55);
    send(25'h108123, 8'h77);
    end_dl();
    chk("fl_n", 64'(sq.size()), 64'd1);
    w = sqw(0);
    chk("fl_a", 64'(w.a), 64'h8);
    chk("fl_lo", 64'(w.d[7:0]), 64'h55);
    chk("fl_be", 64'(w.be), 64'h1);
    chk("br_n", 64'(bq.size()), 64'd1);
    b = bqw(0);
    chk("br_cs", 64'(b.cs), 64'b000100);
    chk("br_d", 64'(b.d), 64'h77);
    chk("br_a", 64'(b.a), 64'h123);
    chk("br_cnt", 64'(byte_count), 64'd2);

    // unmapped byte is dropped with an error
    bq.delete();
    start_dl();
    c0 = req_cyc;
    send(25'h1F0000, 8'h99);
    repeat (3) tick();
    chk("um_err", 64'(err), 64'd1);
    chk("um_cnt", 64'(byte_count), 64'd0);
    chk("um_req", 64'(req_cyc - c0), 64'd0);
    chk("um_bram", 64'(bq.size()), 64'd0);
    end_dl();

    // byte arriving with the skid already full is lost
    lat = 6;
    sq.delete();
    start_dl();
    chk("err_clear", 64'(err), 64'd0);
    send(25'h21, 8'h11);
    ioctl_wr = 1'b1;
    ioctl_addr = 25'h30;
    ioctl_data = 8'h22;
    tick();
    ioctl_addr = 25'h32;
    ioctl_data = 8'h33;
    tick();
    ioctl_wr = 1'b0;
    chk("drop_err", 64'(err), 64'd1);
    end_dl();
    chk("drop_n", 64'(sq.size()), 64'd2);
    w = sqw(0);
    chk("drop0", {w.a, w.d, w.be}, {25'h20, 16'h1100, 2'b10});
    w = sqw(1);
    chk("drop1_a", 64'(w.a), 64'h30);
    chk("drop1_lo", 64'(w.d[7:0]), 64'h22);
    chk("drop1_be", 64'(w.be), 64'h1);
    chk("drop_cnt", 64'(byte_count), 64'd2);

    // reset in the middle of an outstanding write
    lat = 20;
    start_dl();
    send(25'h41, 8'h44);
    tick();
    chk("mid_req", 64'(sdr_req), 64'd1);
    reset = 1'b1;
    tick();
    chk("mr_req", 64'(sdr_req), 64'd0);
    chk("mr_wait", 64'(ioctl_wait), 64'd0);
    chk("mr_sdr", {sdr_addr, sdr_data, sdr_be}, 64'd0);
    chk("mr_bram", {bram_wr, bram_cs, bram_addr, bram_data}, 64'd0);
    chk("mr_flags", {done, err, byte_count}, 64'd0);
    reset = 1'b0;
    ioctl_download = 1'b0;
    repeat (3) tick();

    // random traffic against memory images
    sq.delete();
    bq.delete();
    prev = 25'h1000;
    for (int dl = 0; dl < 4; dl++) begin
      lat = int'($urandom_range(1, 4));
      exp_cnt = 0;
      exp_err = 0;
      start_dl();
      for (int i = 0; i < 60; i++) begin
        r = int'($urandom_range(0, 99));
        if (r < 50) a = 25'h1000 + 25'((prev + 1) & 25'hFF);
        else if (r < 70) a = 25'h1000 + 25'($urandom_range(0, 255));
        else if (r < 92) begin
          reg_k = int'($urandom_range(0, 5));
          a = 25'(bbase[reg_k]) + 25'($urandom_range(0, 255));
        end else a = 25'h1F0000 + 25'($urandom_range(0, 255));
        d = 8'($urandom);
        reg_k = region_of(a);
        if (reg_k < 0) exp_err = 1;
        else begin
          exp_cnt++;
          if (reg_k == 0) begin
            exp_s[int'(a)] = d;
            prev = a;
          end else
            exp_b[((reg_k - 1) << 20) + (int'(a) - bbase[reg_k - 1])] = d;
        end
        send(a, d);
        if ($urandom_range(0, 7) == 0) repeat ($urandom_range(1, 3)) tick();
      end
      end_dl();
      chk("rnd_cnt", 64'(byte_count), 64'(exp_cnt));
      chk("rnd_err", 64'(err), 64'(exp_err));
    end

    bad_a0 = 0;
    foreach (sq[i]) begin
      if (sq[i].a[0]) bad_a0++;
      if (sq[i].be[0]) got_s[int'(sq[i].a)] = sq[i].d[7:0];
      if (sq[i].be[1]) got_s[int'(sq[i].a) + 1] = sq[i].d[15:8];
    end
    bad_cs = 0;
    foreach (bq[i]) begin
      k_found = -1;
      for (int k = 0; k < 6; k++)
        if (bq[i].cs == 6'(1 << k)) k_found = k;
      if (k_found < 0) bad_cs++;
      else got_b[(k_found << 20) + int'(bq[i].a)] = bq[i].d;
    end
    chk("sdr_a0", 64'(bad_a0), 64'd0);
    chk("cs_onehot", 64'(bad_cs), 64'd0);
    chk("sdr_img_n", 64'(got_s.size()), 64'(exp_s.size()));
    chk("bram_img_n", 64'(got_b.size()), 64'(exp_b.size()));
    foreach (exp_s[k])
      chk("sdr_img", got_s.exists(k) ? 64'(got_s[k]) : 64'hFFFF,
          64'(exp_s[k]));
    foreach (exp_b[k])
      chk("bram_img", got_b.exists(k) ? 64'(got_b[k]) : 64'hFFFF,
          64'(exp_b[k]));
    chk("wait_in_req", 64'(wait_bad), 64'd0);
    chk("req_stable", 64'(hold_bad), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rom_region_loader.md
ROM_REGION_LOADER -- requirements
Module: rom_region_loader

Interface
REQ-001 Parameter NUM_BRAM, default 6, number of BRAM regions (1..8).
REQ-002 Parameter ADDR_W, default 25, width of ioctl_addr and sdr_addr.
REQ-003 Parameter BRAM_AW, default 20, width of bram_addr.
REQ-004 Parameter REGIONS, default LOADER_MAP from package, table of NUM_BRAM+1 {base, size} entries; entry 0 = SDRAM.
REQ-005 clk  in  1  system clock; single clock domain, all logic on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 ioctl_download  in  1  download window active.
REQ-008 ioctl_wr  in  1  byte strobe, one cycle per byte.
REQ-009 ioctl_addr  in  ADDR_W  byte address of ioctl_data.
REQ-010 ioctl_data  in  8  byte payload.
REQ-011 ioctl_wait  out  1  backpressure; producer holds off ioctl_wr while high.
REQ-012 sdr_addr / sdr_data / sdr_be  out  ADDR_W / 16 / 2  SDRAM word write (sdr_addr bit 0 always 0).
REQ-013 sdr_req  out  1  level request, held until sdr_rdy.
REQ-014 sdr_rdy  in  1  one-cycle completion pulse from SDRAM channel.
REQ-015 bram_addr / bram_data  out  BRAM_AW / 8  region-relative BRAM write.
REQ-016 bram_cs  out  NUM_BRAM  one-hot region select, valid with bram_wr.
REQ-017 bram_wr  out  1  one-cycle BRAM write strobe.
REQ-018 done  out  1  one-cycle pulse when download has fully drained.
REQ-019 err  out  1  sticky error flag (dropped/unmapped byte).
REQ-020 byte_count  out  ADDR_W  bytes accepted in current download.

Function
REQ-021 Region decode combinational on ioctl_addr: first entry with base <= addr < base+size wins; none matching = unmapped.
REQ-022 BRAM byte: registered one cycle later, bram_wr=1, bram_cs one-hot, bram_addr=addr-base truncated to BRAM_AW; no wait asserted.
REQ-023 SDRAM byte lane: even address -> sdr_data[7:0]/be[0]; odd -> [15:8]/be[1]; little-endian.
REQ-024 States: IDLE, PAIR (low byte held), WRITE (sdr_req high), FLUSH (partial word outstanding).
REQ-025 IDLE + even SDRAM byte -> PAIR, latch byte and word address.
REQ-026 PAIR + odd byte at same word address -> WRITE, sdr_be=2'b11, sdr_req=1 next cycle.
REQ-027 IDLE + odd SDRAM byte (no pair) -> WRITE, sdr_be=2'b10, high byte only.
REQ-028 PAIR + byte at different word address, BRAM byte, or ioctl_download fall -> FLUSH, sdr_be=2'b01; triggering byte is re-processed after flush (held in one-entry skid register).
REQ-029 WRITE/FLUSH: sdr_req stays high, address/data/be stable until sdr_rdy; on sdr_rdy drop sdr_req same edge, return to IDLE, or PAIR/BRAM handling if skid register occupied.
REQ-030 ioctl_wait=1 in WRITE, FLUSH, or while skid register occupied; 0 otherwise.
REQ-031 ioctl_wr while ioctl_wait high and skid full: byte dropped, err set.
REQ-032 Unmapped byte: dropped, err set, byte_count not incremented.
REQ-033 byte_count increments per accepted byte; cleared on ioctl_download rising edge.
REQ-034 done pulses exactly once, the first cycle after ioctl_download low with state IDLE and skid empty.
REQ-035 err cleared only by reset or ioctl_download rising edge.
REQ-036 ioctl_wr with ioctl_download low: ignored, no error.
REQ-037 sdr_rdy in IDLE/PAIR: ignored.

Reset
REQ-038 reset: state IDLE, skid empty, sdr_req=0, sdr_be=0, sdr_addr=0, sdr_data=0, bram_wr=0, bram_cs=0, bram_addr=0, bram_data=0, ioctl_wait=0, done=0, err=0, byte_count=0.
REQ-039 reset mid-WRITE drops sdr_req next edge; the outstanding word is abandoned.

Structure
REQ-040 Package loader_pkg holds region_t {base, size}, LOADER_MAP default table, and state enum.
REQ-041 One sub-module, loader_region_decode (combinational address-to-region lookup).

Verification
REQ-042 Bytes 0x00..0x03 to SDRAM addr 0..3, sdr_rdy 2 cycles after req -> words 0x0100@0, 0x0302@2, be=11, wait high during each req.
REQ-043 Single byte 0xAA@5 then download fall -> one write addr 4, data[15:8]=0xAA, be=10, then done pulse.
REQ-044 Byte 0x55@8, then BRAM region-2 byte 0x77 -> flush addr 8 be=01; then bram_cs=0b000100, bram_data=0x77, bram_addr=offset.
REQ-045 Byte to unmapped addr -> no sdr_req, no bram_wr, err=1, byte_count unchanged.
REQ-046 ioctl_wr asserted while wait high and skid full -> byte dropped, err=1.
REQ-047 reset asserted with sdr_req high -> sdr_req=0 and all outputs at reset values next cycle.
